// File: rtl/mem_access_if.sv
// Bundle of upstream request, data-memory bus and MEM/WB result signals for mem_access.
// master = the memory-access stage; slave = its environment (upstream, memory, MEM/WB).
interface mem_access_if;
  logic        invalid;
  logic        memread;
  logic        memwrite;
  logic [1:0]  memsize;
  logic        memunsigned;
  logic [31:0] aluin;
  logic [31:0] writedata;
  logic [4:0]  rdin;
  logic        regwritein;
  logic        stall;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dbe;
  logic        dack;
  logic [31:0] drdata;
  logic        outvalid;
  logic [31:0] aluresult;
  logic [31:0] memreadout;
  logic [4:0]  rdout;
  logic        regwriteout;
  logic        memtoreg;
  logic        misalign;

  modport master (
    input  invalid, memread, memwrite, memsize, memunsigned, aluin, writedata,
           rdin, regwritein, dack, drdata,
    output stall, dreq, dwe, daddr, dwdata, dbe, outvalid, aluresult,
           memreadout, rdout, regwriteout, memtoreg, misalign
  );

  modport slave (
    output invalid, memread, memwrite, memsize, memunsigned, aluin, writedata,
           rdin, regwritein, dack, drdata,
    input  stall, dreq, dwe, daddr, dwdata, dbe, outvalid, aluresult,
           memreadout, rdout, regwriteout, memtoreg, misalign
  );
endinterface

// File: rtl/mem_access.sv
// MEM stage: single-outstanding req/ack data-memory access with load alignment/extension.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of issuing.
module mem_access (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.master io
);
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_we;
  logic        r_regwr;
  logic [4:0]  r_rd;

  logic        r_outvalid;
  logic [31:0] r_aluresult;
  logic [31:0] r_memreadout;
  logic [4:0]  r_rdout;
  logic        r_regwriteout;
  logic        r_memtoreg;
  logic        r_misalign;

  logic        w_memop;
  logic        w_trap;
  logic        w_busy;
  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane8;
  logic [15:0] w_lane16;
  logic [31:0] w_ldata;

  assign w_memop  = io.memread | io.memwrite;
  assign w_busy   = (r_state == S_BUSY);

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_mis;
  assign w_mis  = ((io.memsize == 2'b01) && io.aluin[0]) ||
                  (io.memsize[1] && (io.aluin[1:0] != 2'b00));
  assign w_trap = io.invalid && w_memop && w_mis;
`else
  assign w_trap = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && io.invalid && w_memop && !w_trap;

  // Store lane steering: data replicated across lanes, enables select the target bytes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = io.writedata;
    case (io.memsize)
      2'b00: begin
        w_be    = 4'b0001 << io.aluin[1:0];
        w_wdata = {4{io.writedata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {io.aluin[1], 1'b0};
        w_wdata = {2{io.writedata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_lane8 = io.drdata[7:0];
    case (r_addr[1:0])
      2'b01:   w_lane8 = io.drdata[15:8];
      2'b10:   w_lane8 = io.drdata[23:16];
      2'b11:   w_lane8 = io.drdata[31:24];
      default: ;
    endcase
    w_lane16 = r_addr[1] ? io.drdata[31:16] : io.drdata[15:0];
    case (r_size)
      2'b00:   w_ldata = {{24{!r_uns && w_lane8[7]}}, w_lane8};
      2'b01:   w_ldata = {{16{!r_uns && w_lane16[15]}}, w_lane16};
      default: w_ldata = io.drdata;
    endcase
  end

  // Reset gates stall so an abandoned transaction never holds upstream.
  assign io.stall  = !rst && (w_accept || (w_busy && !io.dack));
  assign io.dreq   = w_busy;
  assign io.dwe    = w_busy && r_we;
  assign io.daddr  = w_busy ? {r_addr[31:2], 2'b00} : 32'h0;
  assign io.dwdata = w_busy ? r_wdata : 32'h0;
  assign io.dbe    = w_busy ? r_be : 4'h0;

  assign io.outvalid    = r_outvalid;
  assign io.aluresult   = r_aluresult;
  assign io.memreadout  = r_memreadout;
  assign io.rdout       = r_rdout;
  assign io.regwriteout = r_regwriteout;
  assign io.memtoreg    = r_memtoreg;
  assign io.misalign    = r_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_size        <= '0;
      r_uns         <= 1'b0;
      r_we          <= 1'b0;
      r_regwr       <= 1'b0;
      r_rd          <= '0;
      r_outvalid    <= 1'b0;
      r_aluresult   <= '0;
      r_memreadout  <= '0;
      r_rdout       <= '0;
      r_regwriteout <= 1'b0;
      r_memtoreg    <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      r_outvalid <= 1'b0;
      r_misalign <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_addr  <= io.aluin;
          r_wdata <= w_wdata;
          r_be    <= w_be;
          r_size  <= io.memsize;
          r_uns   <= io.memunsigned;
          r_we    <= io.memwrite;
          r_regwr <= io.regwritein;
          r_rd    <= io.rdin;
          r_state <= S_BUSY;
        end else if (io.invalid) begin
          r_outvalid    <= 1'b1;
          r_aluresult   <= io.aluin;
          r_rdout       <= io.rdin;
          r_regwriteout <= io.regwritein && !w_trap;
          r_memreadout  <= '0;
          r_memtoreg    <= 1'b0;
          r_misalign    <= w_trap;
        end
      end else if (io.dack) begin
        r_outvalid    <= 1'b1;
        r_aluresult   <= r_addr;
        r_rdout       <= r_rd;
        r_regwriteout <= r_regwr && !r_we;
        r_memreadout  <= r_we ? 32'h0 : w_ldata;
        r_memtoreg    <= !r_we;
        r_state       <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, stores, loads, wait states, reset abort, back-to-back.
module tb_mem_access;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   nst;

  mem_access_if io();

  mem_access u_dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    io.invalid = 0; io.memread = 0; io.memwrite = 0; io.memsize = 0;
    io.memunsigned = 0; io.aluin = 0; io.writedata = 0; io.rdin = 0;
    io.regwritein = 0; io.dack = 0; io.drdata = 0;
  endtask

  task automatic set_op(input logic rd_, input logic wr_, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rw);
    io.invalid = 1; io.memread = rd_; io.memwrite = wr_; io.memsize = sz;
    io.memunsigned = uns; io.aluin = a; io.writedata = wd; io.rdin = rd;
    io.regwritein = rw;
  endtask

  // Runs an already-presented memory op: accept cycle, `waits` dack-low cycles, then dack.
  task automatic txn(input int waits, input logic [31:0] rdata, input logic [31:0] ea,
                     input logic [3:0] ebe, input logic [31:0] ewd, input logic ewe,
                     output int nstall);
    nstall = 0;
    #1;
    if (io.stall) nstall++;
    tick();
    for (int w = 0; w <= waits; w++) begin
      if (w == waits) begin io.dack = 1; io.drdata = rdata; end
      #1;
      if (io.stall) nstall++;
      chk("dreq_busy", io.dreq, 1);
      chk("daddr", io.daddr, ea);
      chk("dbe", 32'(io.dbe), 32'(ebe));
      chk("dwdata", io.dwdata, ewd);
      chk("dwe", 32'(io.dwe), 32'(ewe));
      chk("outvalid_busy", io.outvalid, 0);
      tick();
      io.dack = 0;
    end
    io.invalid = 0; io.memread = 0; io.memwrite = 0;
  endtask

  initial begin
    clr();
    tick(); tick();
    chk("rst_outvalid", io.outvalid, 0);
    chk("rst_stall", io.stall, 0);
    chk("rst_dreq", io.dreq, 0);
    chk("rst_misalign", io.misalign, 0);
    chk("rst_aluresult", io.aluresult, 0);
    chk("rst_dbe", 32'(io.dbe), 0);
    chk("rst_daddr", io.daddr, 0);
    rst = 0;
    tick();

    // ALU op
    set_op(0, 0, 2'b10, 0, 32'h10, 32'h0, 5'd5, 1);
    #1 chk("alu_stall", io.stall, 0);
    tick();
    io.invalid = 0;
    chk("alu_outvalid", io.outvalid, 1);
    chk("alu_aluresult", io.aluresult, 32'h10);
    chk("alu_rdout", 32'(io.rdout), 5);
    chk("alu_regwrite", io.regwriteout, 1);
    chk("alu_memtoreg", io.memtoreg, 0);
    chk("alu_memreadout", io.memreadout, 0);
    tick();
    chk("bubble_outvalid", io.outvalid, 0);

    // dack while idle is ignored
    io.dack = 1;
    tick();
    chk("idle_dack_outvalid", io.outvalid, 0);
    chk("idle_dack_dreq", io.dreq, 0);
    io.dack = 0;

    // Store byte, dack in first BUSY cycle
    set_op(0, 1, 2'b00, 0, 32'h103, 32'h0000_00AB, 5'd7, 1);
    txn(0, 32'h0, 32'h100, 4'b1000, 32'hABAB_ABAB, 1, nst);
    chk("sb_stall_cycles", nst, 1);
    chk("sb_outvalid", io.outvalid, 1);
    chk("sb_regwrite", io.regwriteout, 0);
    chk("sb_memtoreg", io.memtoreg, 0);
    chk("sb_aluresult", io.aluresult, 32'h103);
    chk("sb_dreq_after", io.dreq, 0);
    tick();
    chk("sb_single_result", io.outvalid, 0);

    // Store half upper pair
    set_op(0, 1, 2'b01, 0, 32'h206, 32'h1234_ABCD, 5'd0, 0);
    txn(1, 32'h0, 32'h204, 4'b1100, 32'hABCD_ABCD, 1, nst);
    chk("sh_stall_cycles", nst, 2);

    // Load half signed, 3 wait cycles
    set_op(1, 0, 2'b01, 0, 32'h202, 32'h0, 5'd9, 1);
    txn(3, 32'h8001_FFFF, 32'h200, 4'b1100, 32'h0, 0, nst);
    chk("lhs_stall_cycles", nst, 4);
    chk("lhs_outvalid", io.outvalid, 1);
    chk("lhs_data", io.memreadout, 32'hFFFF_8001);
    chk("lhs_memtoreg", io.memtoreg, 1);
    chk("lhs_regwrite", io.regwriteout, 1);
    chk("lhs_rdout", 32'(io.rdout), 9);

    // Load half unsigned
    set_op(1, 0, 2'b01, 1, 32'h202, 32'h0, 5'd9, 1);
    txn(3, 32'h8001_FFFF, 32'h200, 4'b1100, 32'h0, 0, nst);
    chk("lhu_stall_cycles", nst, 4);
    chk("lhu_data", io.memreadout, 32'h0000_8001);

    // Byte loads: signed lane 1, unsigned lane 2
    set_op(1, 0, 2'b00, 0, 32'h101, 32'h0, 5'd3, 1);
    txn(0, 32'h1234_80FF, 32'h100, 4'b0010, 32'h0, 0, nst);
    chk("lbs_data", io.memreadout, 32'hFFFF_FF80);
    set_op(1, 0, 2'b00, 1, 32'h102, 32'h0, 5'd3, 1);
    txn(0, 32'h1122_3344, 32'h100, 4'b0100, 32'h0, 0, nst);
    chk("lbu_data", io.memreadout, 32'h0000_0022);

    // Aligned word load
    set_op(1, 0, 2'b10, 0, 32'h400, 32'h0, 5'd4, 1);
    txn(0, 32'hDEAD_BEEF, 32'h400, 4'b1111, 32'h0, 0, nst);
    chk("lw_data", io.memreadout, 32'hDEAD_BEEF);
    chk("lw_misalign", io.misalign, 0);

    // Misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
    set_op(1, 0, 2'b10, 0, 32'h301, 32'h0, 5'd6, 1);
    #1;
    chk("mis_stall", io.stall, 0);
    chk("mis_dreq", io.dreq, 0);
    tick();
    io.invalid = 0; io.memread = 0;
    chk("mis_outvalid", io.outvalid, 1);
    chk("mis_misalign", io.misalign, 1);
    chk("mis_regwrite", io.regwriteout, 0);
    chk("mis_memreadout", io.memreadout, 0);
    chk("mis_aluresult", io.aluresult, 32'h301);
    chk("mis_dreq_after", io.dreq, 0);
    tick();
    chk("mis_pulse", io.misalign, 0);
`else
    set_op(1, 0, 2'b10, 0, 32'h301, 32'h0, 5'd6, 1);
    txn(0, 32'hCAFE_F00D, 32'h300, 4'b1111, 32'h0, 0, nst);
    chk("mis_outvalid", io.outvalid, 1);
    chk("mis_misalign", io.misalign, 0);
    chk("mis_data", io.memreadout, 32'hCAFE_F00D);
    chk("mis_regwrite", io.regwriteout, 1);
`endif

    // Reset while BUSY abandons the transaction
    set_op(1, 0, 2'b10, 0, 32'h600, 32'h0, 5'd8, 1);
    tick();
    #1;
    chk("rb_dreq_before", io.dreq, 1);
    chk("rb_stall_before", io.stall, 1);
    rst = 1;
    #1;
    chk("rb_dreq", io.dreq, 0);
    chk("rb_stall", io.stall, 0);
    chk("rb_outvalid", io.outvalid, 0);
    clr();
    tick();
    rst = 0;
    tick();
    chk("rb_no_result", io.outvalid, 0);
    set_op(0, 0, 2'b00, 0, 32'h77, 32'h0, 5'd2, 1);
    tick();
    io.invalid = 0;
    chk("rb_alu_outvalid", io.outvalid, 1);
    chk("rb_alu_result", io.aluresult, 32'h77);

    // Back-to-back loads, dack in each BUSY cycle
    set_op(1, 0, 2'b10, 0, 32'h500, 32'h0, 5'd1, 1);
    tick();
    io.dack = 1; io.drdata = 32'hAAAA_0001;
    #1 chk("b2b_stall_a", io.stall, 0);
    tick();
    chk("b2b_ov_a", io.outvalid, 1);
    chk("b2b_data_a", io.memreadout, 32'hAAAA_0001);
    chk("b2b_rd_a", 32'(io.rdout), 1);
    set_op(1, 0, 2'b10, 0, 32'h504, 32'h0, 5'd2, 1);
    io.dack = 0;
    #1 chk("b2b_accept_b", io.stall, 1);
    tick();
    chk("b2b_no_dup", io.outvalid, 0);
    io.dack = 1; io.drdata = 32'hBBBB_0002;
    tick();
    clr();
    chk("b2b_ov_b", io.outvalid, 1);
    chk("b2b_data_b", io.memreadout, 32'hBBBB_0002);
    chk("b2b_rd_b", 32'(io.rdout), 2);
    chk("b2b_alu_b", io.aluresult, 32'h504);
    tick();
    chk("b2b_end", io.outvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
